// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers.
//
// Contents:
//   DEF_ADDR_W  default memory address width (depth 2^DEF_ADDR_W)
//   FN_W        working width of the code-conversion helpers
//   bin2gray    binary -> reflected Gray
//   gray2bin    reflected Gray -> binary
//
// The helpers work on a zero-extended FN_W-bit value. Zero bits above a
// pointer's width convert to zero bits, so calling a helper with
// FN_W'(ptr) and keeping the low ADDR_W+1 bits of the result gives the
// conversion at pointer width, for any pointer up to FN_W bits.
package async_fifo_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int FN_W       = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_gray_cnt.sv
// Dual-code (binary + Gray) pointer register, shared by the write-side and
// read-side FIFO controllers.
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset; clears both codes to 0
//   inc        in   advance the pointer by one at the next edge
//   bin        out  current binary pointer (registered)
//   gray       out  current Gray pointer (registered)
//   bin_next   out  binary value after this cycle's increment
//   gray_next  out  Gray value after this cycle's increment
//
// Both codes are stored in flops. The Gray register is therefore glitch-free
// and changes by at most one bit per edge, which makes it safe to hand to a
// synchronizer in another clock domain.
module async_fifo_gray_cnt
  import async_fifo_pkg::*;
#(
  parameter int W = DEF_ADDR_W + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  // Natural modulo-2^W wrap: all-ones + 1 -> 0, Gray 10..0 -> 00..0.
  assign bin_next  = bin + W'(inc);
  assign gray_next = W'(bin2gray(FN_W'(bin_next)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the async FIFO. Everything here
// runs on the write clock.
//
// Ports:
//   clk               in   write-domain clock
//   reset_n           in   synchronous active-low reset
//   wr_en             in   push request, sampled every cycle
//   rd_ptr_gray_sync  in   read pointer (Gray), already synchronized to clk
//   mem_we            out  memory write enable (combinational)
//   mem_waddr         out  memory write address
//   wr_ptr_gray       out  registered Gray write pointer for the read domain
//   full              out  registered full flag; pushes ignored while high
//   almost_full       out  registered, fill count >= AFULL_THRESH
//   wr_count          out  registered fill level, 0..2^ADDR_W
//   overflow          out  registered one-cycle pulse: push attempted while full
//
// The read pointer arrives late through the synchronizer, so full and
// wr_count lag reads and always err toward "fuller than it really is".
// That pessimism is intended: full can never drop before the slot is free.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray_sync,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] count_next;
  logic          full_next;
  logic          afull_next;

  // Reset gating keeps the memory untouched while the block is held in reset.
  assign mem_we    = wr_en && !full && reset_n;
  assign mem_waddr = wbin[ADDR_W-1:0];

  async_fifo_gray_cnt #(.W(PW)) u_wptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (mem_we),
    .bin       (wbin),
    .gray      (wr_ptr_gray),
    .bin_next  (wbin_next),
    .gray_next (wgray_next)
  );

  assign rgray = rd_ptr_gray_sync;
  assign rbin  = PW'(gray2bin(FN_W'(rgray)));

  // Writer is exactly one lap (2^ADDR_W entries) ahead of the reader when
  // its Gray pointer equals the reader's with the top two bits inverted.
  assign full_gray  = {~rgray[PW-1:PW-2], rgray[PW-3:0]};
  assign full_next  = (wgray_next == full_gray);
  assign count_next = wbin_next - rbin;
  assign afull_next = (count_next >= PW'(AFULL_THRESH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      full        <= full_next;
      almost_full <= afull_next;
      wr_count    <= count_next;
      overflow    <= wr_en && full;
    end
  end

`ifdef ASSERT_ON
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_W);

  if (ADDR_W < 2 || AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_W)) begin : g_bad_param
    $error("async_fifo_wr_ctrl: ADDR_W must be >= 2 and AFULL_THRESH in 1..2^ADDR_W");
  end

  // Reset legitimately moves the pointer by several bits, so only check
  // cycles where the previous edge was not a reset edge.
  a_gray_one_bit: assert property (@(posedge clk) disable iff (!reset_n)
    $past(reset_n) |-> ($countones(wr_ptr_gray ^ $past(wr_ptr_gray)) <= 1));

  a_no_write_when_full: assert property (@(posedge clk) !(full && mem_we));

  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    wr_count <= DEPTH);
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] rd_ptr_gray_sync;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;

  async_fifo_wr_ctrl #(.ADDR_W(4), .AFULL_THRESH(12)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: total entries ever accepted and ever read, as plain
  // integers. Level is their difference; flags follow from the level.
  int  wptr  = 0;
  int  rptr  = 0;
  bit  e_full = 1'b0;
  bit  e_af   = 1'b0;
  bit  e_ovf  = 1'b0;
  int  e_cnt  = 0;
  bit  prev_rst = 1'b1;
  logic [4:0] prev_gray;
  bit  saw_wrap = 1'b0;

  function automatic logic [4:0] gray5(input int v);
    int m;
    m = v % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model at the edge, then check registered outputs.
  task automatic step(input bit rst, input bit wr, input int rp);
    reset_n          = !rst;
    wr_en            = wr;
    rptr             = rp;
    rd_ptr_gray_sync = gray5(rp);
    #1;
    chk("mem_we", 32'(mem_we), 32'(!rst && wr && !e_full));
    chk("mem_waddr", 32'(mem_waddr), 32'(wptr % 16));
    @(posedge clk);
    if (rst) begin
      wptr = 0; e_full = 0; e_af = 0; e_ovf = 0; e_cnt = 0;
    end else begin
      e_ovf = wr && e_full;
      if (wr && !e_full) wptr++;
      e_cnt  = wptr - rptr;
      e_full = (e_cnt == 16);
      e_af   = (e_cnt >= 12);
    end
    #1;
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(rst ? 5'd0 : gray5(wptr)));
    chk("full", 32'(full), 32'(e_full));
    chk("almost_full", 32'(almost_full), 32'(e_af));
    chk("wr_count", 32'(wr_count), 32'(e_cnt));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    if (!rst && !prev_rst)
      chk("gray_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray) <= 1), 32'd1);
    if (!rst && !prev_rst && prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000)
      saw_wrap = 1'b1;
    prev_gray = wr_ptr_gray;
    prev_rst  = rst;
  endtask

  initial begin
    // Reset held 2 cycles with wr_en high
    step(1, 1, 0);
    step(1, 1, 0);

    // Fill 16 back-to-back with reader idle
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(wr_count), 32'd16);
    chk("fill_gray", 32'(wr_ptr_gray), 32'h18);

    // Overflow: 17th push while full
    step(0, 1, 0);
    chk("ovf_gray_hold", 32'(wr_ptr_gray), 32'h18);
    step(0, 0, 0);

    // Release, then push with simultaneous read advance
    step(0, 0, 1);
    chk("release_count", 32'(wr_count), 32'd15);
    step(0, 1, 2);
    chk("release_push_count", 32'(wr_count), 32'd15);

    // Drain one entry per cycle to wptr-3, then 40 pushes with reader at wptr-3
    while (rptr < wptr - 3) step(0, 0, rptr + 1);
    for (int i = 0; i < 40; i++) step(0, 1, wptr - 3);
    chk("wrap_seen", 32'(saw_wrap), 32'd1);

    // Random pushes and single-step read advances
    for (int i = 0; i < 300; i++) begin
      bit w;
      int rp;
      w  = 1'($urandom_range(0, 1));
      rp = rptr;
      if (rptr < wptr && $urandom_range(0, 2) == 0) rp = rptr + 1;
      step(0, w, rp);
    end

    // Steer level to 9, then reset mid-operation (reader resets too)
    while (wptr - rptr < 9) step(0, 1, rptr);
    while (wptr - rptr > 9) step(0, 0, rptr + 1);
    chk("pre_rst_count", 32'(wr_count), 32'd9);
    step(1, 1, 0);
    chk("post_rst_waddr", 32'(mem_waddr), 32'd0);
    step(0, 1, 0);
    chk("post_rst_count", 32'(wr_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
